// File: rtl/adc_spi_multi_master.sv
// SPI master for NUM_CH simultaneous-sampling ADCs. They share SCLK and SDI; each ADC has its own SDO and SYNC_N.
// Latency: RX_VALID rises (2*FRAME_W+2)*CLK_DIV cycles after the accepting edge, and BUSY stays high for GAP more cycles.
// No backpressure: START is sampled only while idle, and START during BUSY is dropped without being queued.
module adc_spi_multi_master #(
  parameter int NUM_CH  = 4,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0,
  parameter int GAP     = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic [FRAME_W-1:0]          TX_DATA,
  input  logic [NUM_CH-1:0]           CH_EN,
  input  logic [NUM_CH-1:0]           SDO,
  output logic                        SCLK,
  output logic                        SDI,
  output logic [NUM_CH-1:0]           SYNC_N,
  output logic [NUM_CH*FRAME_W-1:0]   RX_DATA,
  output logic                        RX_VALID,
  output logic                        BUSY
);

  localparam int DW       = $clog2(CLK_DIV + 1);
  localparam int BW       = $clog2(FRAME_W + 1);
  localparam int GW       = $clog2(GAP + 2);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_LAST);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LEAD  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]                      state;
  logic [DW-1:0]                   div_cnt;
  logic [BW-1:0]                   bit_cnt;
  logic [GW-1:0]                   gap_cnt;
  // The MSB of the command goes straight to SDI on accept, so only the remaining bits are kept.
  logic [FRAME_W-2:0]              tx_sh;
  logic [NUM_CH-1:0]               ch_en_q;
  logic [NUM_CH-1:0][FRAME_W-1:0]  rx_sh;
  logic [NUM_CH*FRAME_W-1:0]       rx_next;

  // Shift one SDO bit into every channel's register, LSB in, so the first bit received ends up as the MSB.
  function automatic logic [NUM_CH-1:0][FRAME_W-1:0] shift_in(
    input logic [NUM_CH-1:0][FRAME_W-1:0] cur,
    input logic [NUM_CH-1:0]              din
  );
    logic [NUM_CH-1:0][FRAME_W-1:0] res;
    for (int i = 0; i < NUM_CH; i++) begin
      res[i] = {cur[i][FRAME_W-2:0], din[i]};
    end
    return res;
  endfunction

  // Build the result word. Slots that were disabled when the frame was accepted read as zero.
  always_comb begin
    rx_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rx_next[i*FRAME_W +: FRAME_W] = ch_en_q[i] ? rx_sh[i] : '0;
    end
  end

  // Frame sequencer. SCLK, SDI and SYNC_N are driven straight from registers so they cannot glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sh    <= '0;
      ch_en_q  <= '0;
      rx_sh    <= '0;
      SCLK     <= CPOL;
      SDI      <= 1'b0;
      SYNC_N   <= '1;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && (CH_EN != '0)) begin
            tx_sh   <= TX_DATA[FRAME_W-2:0];
            ch_en_q <= CH_EN;
            SDI     <= TX_DATA[FRAME_W-1];
            SYNC_N  <= ~CH_EN;
            BUSY    <= 1'b1;
            bit_cnt <= BW'(FRAME_W);
            div_cnt <= DIV_LAST;
            state   <= S_SETUP;
          end
        end
        S_SETUP, S_TRAIL: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else if (bit_cnt != '0) begin
            // Leading edge: the ADCs have had a full half-period to present their SDO bit.
            SCLK    <= ~CPOL;
            rx_sh   <= shift_in(rx_sh, SDO);
            bit_cnt <= bit_cnt - BW'(1);
            div_cnt <= DIV_LAST;
            state   <= S_LEAD;
          end else begin
            div_cnt <= DIV_LAST;
            state   <= S_HOLD;
          end
        end
        S_LEAD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else begin
            SCLK    <= CPOL;
            div_cnt <= DIV_LAST;
            state   <= S_TRAIL;
            if (bit_cnt != '0) begin
              SDI   <= tx_sh[FRAME_W-2];
              tx_sh <= tx_sh << 1;
            end
          end
        end
        S_HOLD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else begin
            SYNC_N   <= '1;
            RX_DATA  <= rx_next;
            RX_VALID <= 1'b1;
            if (GAP == 0) begin
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gap_cnt <= GAP_INIT;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_multi_master.sv
// Bench for adc_spi_multi_master. It drives three instances: A (CLK_DIV=2, CPOL=0), B (CLK_DIV=1, CPOL=1) and C (FRAME_W=2, NUM_CH=1, GAP=0).
// A timing model checks A and B on every cycle; literal expectations pin the model, and C is checked with directed tests.
module tb_adc_spi_multi_master;
  localparam int FW  = 16;
  localparam int GAP = 2;

  logic clk, rst, sel;
  logic start, start_c, ch_en_c, sdo_c;
  logic [15:0] tx;
  logic [3:0]  ch_en, sdo_a, sdo_b;
  logic [1:0]  tx_c, adc_c;
  logic [15:0] adc_w [4];

  logic sclk_a, sdi_a, vld_a, busy_a, sclk_b, sdi_b, vld_b, busy_b;
  logic sclk_c, sdi_c, vld_c, busy_c;
  logic [3:0]  sync_a, sync_b;
  logic [0:0]  sync_c;
  logic [63:0] rx_a, rx_b;
  logic [1:0]  rx_c;

  int checks = 0;
  int errors = 0;
  int cyc, acc, cd, lead_cnt, vld_ofs, sync_run, gap_run;
  int busy_rise[$];
  bit have;
  logic cpol, psclk, pbusy;
  logic [15:0] tx_m, sdi_cap;
  logic [3:0]  ch_m;
  logic [63:0] rx_old, rx_new;

  adc_spi_multi_master #(.NUM_CH(4), .FRAME_W(16), .CLK_DIV(2), .CPOL(1'b0), .GAP(2)) u_a (
    .CLK(clk), .RST(rst), .START(start & ~sel), .TX_DATA(tx), .CH_EN(ch_en), .SDO(sdo_a),
    .SCLK(sclk_a), .SDI(sdi_a), .SYNC_N(sync_a), .RX_DATA(rx_a), .RX_VALID(vld_a), .BUSY(busy_a));

  adc_spi_multi_master #(.NUM_CH(4), .FRAME_W(16), .CLK_DIV(1), .CPOL(1'b1), .GAP(2)) u_b (
    .CLK(clk), .RST(rst), .START(start & sel), .TX_DATA(tx), .CH_EN(ch_en), .SDO(sdo_b),
    .SCLK(sclk_b), .SDI(sdi_b), .SYNC_N(sync_b), .RX_DATA(rx_b), .RX_VALID(vld_b), .BUSY(busy_b));

  adc_spi_multi_master #(.NUM_CH(1), .FRAME_W(2), .CLK_DIV(3), .CPOL(1'b0), .GAP(0)) u_c (
    .CLK(clk), .RST(rst), .START(start_c), .TX_DATA(tx_c), .CH_EN(ch_en_c), .SDO(sdo_c),
    .SCLK(sclk_c), .SDI(sdi_c), .SYNC_N(sync_c), .RX_DATA(rx_c), .RX_VALID(vld_c), .BUSY(busy_c));

  // The model watches whichever of A or B is currently selected.
  wire        o_sclk = sel ? sclk_b : sclk_a;
  wire        o_sdi  = sel ? sdi_b  : sdi_a;
  wire        o_vld  = sel ? vld_b  : vld_a;
  wire        o_busy = sel ? busy_b : busy_a;
  wire [3:0]  o_sync = sel ? sync_b : sync_a;
  wire [63:0] o_rx   = sel ? rx_b   : rx_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC models: each ADC presents bit (FW-1-L) of its word, where L is the number of leading SCLK edges seen so far.
  initial begin
    int la, lb, lc;
    logic pa, pb, pc;
    la = 0; lb = 0; lc = 0; pa = 1'b0; pb = 1'b1; pc = 1'b0;
    sdo_a = '0; sdo_b = '0; sdo_c = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sync_a == 4'hF) la = 0; else if (sclk_a && !pa) la++;
      if (sync_b == 4'hF) lb = 0; else if (!sclk_b && pb) lb++;
      if (sync_c[0])      lc = 0; else if (sclk_c && !pc) lc++;
      pa = sclk_a; pb = sclk_b; pc = sclk_c;
      for (int i = 0; i < 4; i++) begin
        sdo_a[i] = (la < FW) ? adc_w[i][FW-1-la] : 1'b0;
        sdo_b[i] = (lb < FW) ? adc_w[i][FW-1-lb] : 1'b0;
      end
      sdo_c = (lc < 2) ? adc_c[1-lc] : 1'b0;
    end
  end

  // Cycle model for A and B. Every output is computed from n, the number of cycles since the accepting edge.
  initial begin : model
    int n, v, k;
    logic [3:0]  e_sync;
    logic        e_sclk, e_sdi, e_vld, e_busy;
    logic [63:0] e_rx;
    cyc = 0; acc = 0; have = 1'b0; rx_old = '0; rx_new = '0; tx_m = '0; ch_m = '0;
    lead_cnt = 0; sdi_cap = '0; psclk = 1'b0; pbusy = 1'b0; vld_ofs = -1; sync_run = 0; gap_run = 0;
    forever begin
      @(negedge clk);
      cd = sel ? 1 : 2;
      cpol = sel;
      if (rst) begin
        chk("rst_sclk", o_sclk, cpol);
        chk("rst_sync", o_sync, 4'hF);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_vld",  o_vld,  1'b0);
        chk("rst_rx",   o_rx,   64'h0);
        have = 1'b0; rx_old = '0; psclk = cpol; pbusy = 1'b0; sync_run = 0;
      end else begin
        n = cyc - acc;
        v = (2*FW + 2) * cd;
        if (have && n < v) begin
          e_sync = ~ch_m; e_busy = 1'b1; e_vld = 1'b0; e_rx = rx_old;
          if (n < cd || n >= (2*FW + 1) * cd) e_sclk = cpol;
          else e_sclk = (((n / cd) - 1) % 2 == 0) ? ~cpol : cpol;
          k = n / (2 * cd);
          if (k > FW - 1) k = FW - 1;
          e_sdi = tx_m[FW-1-k];
        end else begin
          e_sync = 4'hF; e_sclk = cpol;
          e_vld  = have && (n == v);
          e_busy = have && (n < v + GAP);
          e_rx   = have ? rx_new : rx_old;
          e_sdi  = have ? tx_m[0] : 1'b0;
        end
        chk("sclk", o_sclk, e_sclk);
        chk("sdi",  o_sdi,  e_sdi);
        chk("sync", o_sync, e_sync);
        chk("busy", o_busy, e_busy);
        chk("vld",  o_vld,  e_vld);
        chk("rx",   o_rx,   e_rx);
        // Observations of the DUT used by the literal checks.
        if (o_sclk != psclk && o_sclk == ~cpol) begin
          lead_cnt++;
          sdi_cap = {sdi_cap[14:0], o_sdi};
        end
        psclk = o_sclk;
        if (o_busy && !pbusy) begin
          busy_rise.push_back(cyc);
          gap_run = sync_run;
        end
        pbusy = o_busy;
        if (o_vld && busy_rise.size() > 0) vld_ofs = cyc - busy_rise[$];
        sync_run = (o_sync == 4'hF) ? sync_run + 1 : 0;
        if (!e_busy && start && ch_en != 4'h0) begin
          if (have) rx_old = rx_new;
          acc = cyc + 1; have = 1'b1; tx_m = tx; ch_m = ch_en;
          for (int i = 0; i < 4; i++) rx_new[i*16 +: 16] = ch_en[i] ? adc_w[i] : 16'h0;
          lead_cnt = 0; sdi_cap = '0;
        end
      end
      cyc++;
    end
  end

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_vld) begin ok = 1'b1; break; end
    end
    chk("valid_timeout", ok, 1'b1);
    #1;
  endtask

  task automatic run_frame(input logic [15:0] t, input logic [3:0] m);
    @(posedge clk); #1; start = 1'b1; tx = t; ch_en = m;
    @(posedge clk); #1; start = 1'b0;
    wait_valid(200);
    repeat (GAP + 2) @(posedge clk);
    #1;
  endtask

  // Run one C frame and return the number of cycles from the accepting edge to RX_VALID, plus the SDI bits seen on leading edges.
  task automatic frame_c(input logic [1:0] t, input logic [1:0] w, output int lat, output logic [1:0] cap);
    logic ps;
    lat = -1; cap = 2'b00; ps = sclk_c;
    adc_c = w; tx_c = t; ch_en_c = 1'b1; start_c = 1'b1;
    @(posedge clk); #1; start_c = 1'b0;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk); #1;
      if (sclk_c && !ps) cap = {cap[0], sdi_c};
      ps = sclk_c;
      if (vld_c) begin lat = i; break; end
    end
  endtask

  initial begin
    int base, lat;
    logic [1:0] cap;
    rst = 1'b1; sel = 1'b0; start = 1'b0; tx = '0; ch_en = '0;
    start_c = 1'b0; tx_c = '0; ch_en_c = 1'b0; adc_c = 2'b10;
    adc_w[0] = 16'h1234; adc_w[1] = 16'h8001; adc_w[2] = 16'hFFFF; adc_w[3] = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_lit_sclk_a", sclk_a, 1'b0);
    chk("rst_lit_sclk_b", sclk_b, 1'b1);
    chk("rst_lit_sync_a", sync_a, 4'hF);
    chk("rst_lit_sdi_a",  sdi_a,  1'b0);
    chk("rst_lit_sync_c", sync_c, 1'b1);
    rst = 1'b0;

    // Basic frame on A.
    run_frame(16'hA5C3, 4'hF);
    chk("basic_latency", vld_ofs, 68);
    chk("basic_rx",      rx_a, 64'h0000_FFFF_8001_1234);
    chk("basic_sdi",     sdi_cap, 16'hA5C3);
    chk("basic_edges",   lead_cnt, 16);

    // Channel mask, then a request with no channels enabled.
    @(posedge clk); #1; start = 1'b1; tx = 16'h3C5A; ch_en = 4'b0101;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mask_sync", sync_a, 4'b1010);
    wait_valid(200);
    chk("mask_rx", rx_a, 64'h0000_FFFF_0000_1234);
    repeat (4) @(posedge clk);
    #1; start = 1'b1; ch_en = 4'h0;
    repeat (3) @(posedge clk);
    #1; chk("empty_mask_busy", busy_a, 1'b0);
    start = 1'b0;

    // Back-to-back with START held high. TX/CH_EN change while a frame is running.
    base = busy_rise.size();
    @(posedge clk); #1; start = 1'b1; tx = 16'h0F0F; ch_en = 4'hF;
    for (int i = 0; i < 400 && busy_rise.size() < base + 3; i++) begin
      @(posedge clk); #1;
      if (i == 20) begin tx = 16'hF00F; ch_en = 4'h5; end
    end
    start = 1'b0;
    chk("b2b_count", busy_rise.size() >= base + 3, 1'b1);
    if (busy_rise.size() >= base + 3) begin
      chk("b2b_spacing1", busy_rise[base+1] - busy_rise[base], 71);
      chk("b2b_spacing2", busy_rise[base+2] - busy_rise[base+1], 71);
    end
    chk("b2b_sync_gap", gap_run >= 2, 1'b1);
    wait_valid(200);
    repeat (4) @(posedge clk);

    // Reset in the middle of a frame.
    @(posedge clk); #1; start = 1'b1; tx = 16'h1357; ch_en = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 200 && lead_cnt < 7; i++) begin @(negedge clk); #1; end
    chk("rst_mid_reach", lead_cnt, 7);
    @(posedge clk); #2; rst = 1'b1;
    #1;
    chk("rst_mid_sync", sync_a, 4'hF);
    chk("rst_mid_sclk", sclk_a, 1'b0);
    chk("rst_mid_busy", busy_a, 1'b0);
    chk("rst_mid_rx",   rx_a, 64'h0);
    @(posedge clk); #2; rst = 1'b0;
    run_frame(16'hA5C3, 4'hF);
    chk("after_rst_latency", vld_ofs, 68);
    chk("after_rst_rx", rx_a, 64'h0000_FFFF_8001_1234);

    // Switch the model to B while reset is held.
    @(posedge clk); #2; rst = 1'b1; sel = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    chk("b_idle_sclk", sclk_b, 1'b1);
    run_frame(16'hA5C3, 4'hF);
    chk("b_latency", vld_ofs, 34);
    chk("b_rx",      rx_b, 64'h0000_FFFF_8001_1234);
    chk("b_sdi",     sdi_cap, 16'hA5C3);
    chk("b_edges",   lead_cnt, 16);

    // C: 2-bit frames, GAP=0, and a second accept on the cycle right after RX_VALID.
    @(posedge clk); #1;
    frame_c(2'b01, 2'b10, lat, cap);
    chk("c_latency1", lat, 18);
    chk("c_rx1",      rx_c, 2'b10);
    chk("c_sdi1",     cap, 2'b01);
    chk("c_busy_at_valid", busy_c, 1'b0);
    frame_c(2'b10, 2'b01, lat, cap);
    chk("c_latency2", lat, 18);
    chk("c_rx2",      rx_c, 2'b01);
    chk("c_sdi2",     cap, 2'b10);
    ch_en_c = 1'b0; start_c = 1'b1;
    repeat (3) @(posedge clk);
    #1; chk("c_empty_busy", busy_c, 1'b0);
    start_c = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_spi_multi_master.md
Name: adc_spi_multi_master

Overview:
- Parametrised SPI master that serves NUM_CH simultaneous-sampling ADCs. The ADCs share SCLK and SDI; each has its own SDO and active-low SYNC.
- Generates SCLK from the system clock, runs one full-duplex frame on all enabled channels in parallel, and returns per-channel words with a single-cycle valid strobe.
- Sits between the ADC pins and the sample-processing logic. Replaces the fixed single-channel ADC SPI interface.

Parameters:
- NUM_CH, 4: number of ADC channels (1..16).
- FRAME_W, 16: bits per frame, both TX command and RX word (2..32).
- CLK_DIV, 4: CLK cycles per SCLK half-period (>=1).
- CPOL, 0: SCLK idle level.
- GAP, 2: minimum CLK cycles with all SYNC_N high between frames (>=0).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  frame request; sampled only when BUSY=0.
- TX_DATA  in  FRAME_W  command word; latched on accept; sent MSB first on SDI.
- CH_EN  in  NUM_CH  channel enable mask; latched on accept.
- SDO  in  NUM_CH  per-channel ADC serial data out.
- SCLK  out  1  SPI clock.
- SDI  out  1  shared serial data to the ADCs.
- SYNC_N  out  NUM_CH  per-channel frame select, active low.
- RX_DATA  out  NUM_CH*FRAME_W  received words; channel i occupies bits [i*FRAME_W +: FRAME_W].
- RX_VALID  out  1  one-cycle pulse when RX_DATA is updated.
- BUSY  out  1  high from accept until the gap ends.

Behaviour:
- Reset values (applied immediately and asynchronously): SCLK=CPOL, SDI=0, SYNC_N=all 1, RX_DATA=0, RX_VALID=0, BUSY=0, state=IDLE.
- States: IDLE, SETUP, LEAD, TRAIL, HOLD, GAP.
- IDLE:
  - START=1 and CH_EN!=0: accept. On that edge latch TX_DATA and CH_EN, set BUSY=1, SYNC_N[i]=~CH_EN[i], SDI=TX_DATA[FRAME_W-1]; go to SETUP.
  - START=1 with CH_EN==0: ignored.
- SETUP: CLK_DIV cycles with SCLK=CPOL, then go to LEAD.
- LEAD:
  - On the entry edge, drive SCLK=~CPOL and capture each SDO[i] into shift register i, LSB in, shift left.
  - Hold for CLK_DIV cycles, then go to TRAIL.
- TRAIL:
  - On the entry edge, drive SCLK=CPOL.
  - If bits remain, SDI takes the next TX bit.
  - After CLK_DIV cycles: go to LEAD if bits remain, else HOLD.
- Frame length: exactly FRAME_W LEAD/TRAIL pairs. A bit counter counts FRAME_W down to 0.
- HOLD: CLK_DIV cycles with SCLK=CPOL and SDI held. On exit:
  - SYNC_N goes all high.
  - RX_DATA updates: enabled slots take their shift register; disabled slots become 0.
  - RX_VALID=1 for that one cycle.
- GAP:
  - BUSY stays 1 for GAP cycles, then clears and the state returns to IDLE.
  - If GAP=0, BUSY clears on the same edge that pulses RX_VALID.
- Latency: RX_VALID goes high (2*FRAME_W+2)*CLK_DIV cycles after the accepting edge.
- Accept cadence: the next accept can occur (2*FRAME_W+2)*CLK_DIV+GAP+1 cycles after the previous one.
- START while BUSY=1: ignored; no queueing.
- TX_DATA and CH_EN changes while BUSY=1: no effect on the current frame.
- RX_DATA is stable between RX_VALID pulses.
- SDO sampling: sampled only on LEAD entry edges. SDO values of disabled channels are ignored.
- RST mid-frame: frame aborted with no RX_VALID; RX_DATA clears to 0; first START after RST deassertion is accepted normally.
- SCLK and SDI are registered outputs, glitch-free. SCLK toggles only inside LEAD/TRAIL.

Test Plan:
- Basic frame (NUM_CH=4, FRAME_W=16, CLK_DIV=2, CPOL=0, GAP=2):
  - Stimulus: START with TX_DATA=16'hA5C3, CH_EN=4'hF; ADC models return 16'h1234, 16'h8001, 16'hFFFF, 16'h0000.
  - Required: SDI serialises A5C3 MSB first; exactly 16 SCLK rising edges; RX_VALID at cycle 68 after accept; RX_DATA=64'h0000_FFFF_8001_1234.
- Channel mask:
  - Stimulus: CH_EN=4'b0101.
  - Required: SYNC_N=4'b1010 during the frame; slots 1 and 3 read 0; START with CH_EN=0 leaves BUSY=0.
- Back-to-back:
  - Stimulus: hold START=1 continuously.
  - Required: accepts are 71 cycles apart; SYNC_N high for >=2 cycles between frames; START pulses while BUSY produce no extra frame.
- CPOL=1, CLK_DIV=1:
  - Required: SCLK idles high with a 2-cycle period; data matches the same stimulus as the basic frame.
- Reset mid-frame:
  - Stimulus: assert RST after the 7th SCLK leading edge.
  - Required: SYNC_N=all 1, SCLK=CPOL, BUSY=0 immediately; no RX_VALID; a following frame completes correctly.
- Width corner (FRAME_W=2, NUM_CH=1):
  - Required: RX_VALID at cycle 6*CLK_DIV after accept; the 2-bit word is correct.
